// File: rtl/bus_pkg.sv
// Shared constants for the CPU-side bus initiator:
// FSM encoding, response codes and select-width helper.
package bus_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  localparam logic BUS_OK  = 1'b0;
  localparam logic BUS_ERR = 1'b1;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int NSLAVE_DFLT = 4;
  localparam int SEL_W       = sel_width(NSLAVE_DFLT);

endpackage

// File: rtl/slave_decoder.sv
// Address to slave-index decode for the bus initiator.
// Purely combinational: index field plus one-hot select.
module slave_decoder
  import bus_pkg::*;
#(
  parameter  int NSLAVE  = NSLAVE_DFLT,
  parameter  int SLV_LSB = 28,
  localparam int SW      = (NSLAVE == NSLAVE_DFLT) ?
                           SEL_W : sel_width(NSLAVE)
) (
  input  logic [31:0]       addr,
  output logic [SW-1:0]     sel,
  output logic [NSLAVE-1:0] onehot
);

  logic unused_addr;

  assign sel         = addr[SLV_LSB +: SW];
  assign onehot      = NSLAVE'(1) << sel;
  // only the index field matters here
  assign unused_addr = ^addr;

endmodule

// File: rtl/ahb_master.sv
// CPU load/store to AHB-style bus initiator:
// one transfer at a time, IDLE -> ADDR -> DATA -> IDLE.
module ahb_master
  import bus_pkg::*;
#(
  parameter int NSLAVE  = NSLAVE_DFLT,
  parameter int SLV_LSB = 28,
  parameter int TIMEOUT = 255
) (
  input  logic                 Hclock,
  input  logic                 Hreset,
  input  logic                 cpu_req,
  input  logic                 cpu_write,
  input  logic                 cpu_size,
  input  logic [31:0]          cpu_addr,
  input  logic [31:0]          cpu_wdata,
  output logic                 cpu_busy,
  output logic                 cpu_done,
  output logic                 cpu_err,
  output logic [31:0]          cpu_rdata,
  output logic [NSLAVE-1:0]    Hselect,
  output logic                 ready,
  output logic [31:0]          Haddress,
  output logic                 Hwrite,
  output logic                 Hsize,
  output logic [31:0]          Hwritedata,
  input  logic [32*NSLAVE-1:0] Hreaddata,
  input  logic [NSLAVE-1:0]    Hready,
  input  logic [NSLAVE-1:0]    Hresponse
);

  localparam int SW = sel_width(NSLAVE);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic [SW-1:0]     sel_q, sel_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [NSLAVE-1:0] hsel_q, hsel_d;
  logic              ready_q, ready_d;
  logic [31:0]       addr_q, addr_d;
  logic              write_q, write_d;
  logic              size_q, size_d;
  logic [31:0]       wdata_q, wdata_d;

  logic [SW-1:0]     dec_sel;
  logic [NSLAVE-1:0] dec_onehot;
  logic [31:0]       lane_rdata;
  logic              lane_ready;
  logic              lane_resp;

  slave_decoder #(
    .NSLAVE  (NSLAVE),
    .SLV_LSB (SLV_LSB)
  ) u_dec (
    .addr   (cpu_addr),
    .sel    (dec_sel),
    .onehot (dec_onehot)
  );

  assign lane_rdata = Hreaddata[32*sel_q +: 32];
  assign lane_ready = Hready[sel_q];
  assign lane_resp  = Hresponse[sel_q];

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = BUS_OK;
    rdata_d = rdata_q;
    hsel_d  = hsel_q;
    ready_d = ready_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          addr_d  = cpu_addr;
          write_d = cpu_write;
          size_d  = cpu_size;
          wdata_d = cpu_wdata;
          sel_d   = dec_sel;
          hsel_d  = dec_onehot;
          ready_d = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        ready_d = 1'b0;
        cnt_d   = '0;
        state_d = ST_DATA;
      end
      ST_DATA: begin
        if (lane_ready) begin
          // error responses carry no valid load data
          if (!write_q && lane_resp == BUS_OK)
            rdata_d = lane_rdata;
          err_d   = lane_resp;
          done_d  = 1'b1;
          hsel_d  = '0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          if (cnt_q != TO_MAX)
            cnt_d = cnt_q + CW'(1);
          if (cnt_q >= TO_LAST) begin
            err_d   = BUS_ERR;
            done_d  = 1'b1;
            hsel_d  = '0;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Hclock or negedge Hreset) begin
    if (!Hreset) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      hsel_q  <= '0;
      ready_q <= 1'b0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      hsel_q  <= hsel_d;
      ready_q <= ready_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
    end
  end

  assign cpu_busy   = busy_q;
  assign cpu_done   = done_q;
  assign cpu_err    = err_q;
  assign cpu_rdata  = rdata_q;
  assign Hselect    = hsel_q;
  assign ready      = ready_q;
  assign Haddress   = addr_q;
  assign Hwrite     = write_q;
  assign Hsize      = size_q;
  assign Hwritedata = wdata_q;

endmodule
